// File: rtl/vc_crossbar4_arb_if.sv
// rtl/vc_crossbar4_arb_if.sv - request/response bundle for the 4x4 crossbar arbiter
interface vc_crossbar4_arb_if;
   logic [3:0] in_val;
   logic [7:0] in_dest;
   logic [3:0] in_last;
   logic [3:0] in_rdy;
   logic [3:0] out_val;
   logic [3:0] out_rdy;
   logic [1:0] sel0;
   logic [1:0] sel1;
   logic [1:0] sel2;
   logic [1:0] sel3;

   modport master (
      output in_val, in_dest, in_last, out_rdy,
      input  in_rdy, out_val, sel0, sel1, sel2, sel3
   );

   modport slave (
      input  in_val, in_dest, in_last, out_rdy,
      output in_rdy, out_val, sel0, sel1, sel2, sel3
   );
endinterface

// File: rtl/vc_crossbar4_arb.sv
// rtl/vc_crossbar4_arb.sv - 4x4 crossbar allocator, per-output round-robin with packet lock
module vc_crossbar4_arb #(
   parameter bit p_lock_en = 1'b1
) (
   input logic              clk,
   input logic              reset,
   vc_crossbar4_arb_if.slave xb
);

   typedef enum logic {st_idle, st_locked} state_t;

   state_t     state_q [4];
   state_t     state_d [4];
   logic [1:0] owner_q [4];
   logic [1:0] owner_d [4];
   logic [1:0] ptr_q   [4];
   logic [1:0] ptr_d   [4];

   logic [3:0] req     [4];
   logic [3:0] gnt_v;
   logic [1:0] gnt     [4];
   logic [1:0] sel     [4];
   logic [3:0] rdy_raw;

   always_comb begin
      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < 4; i++) begin
            req[j][i] = xb.in_val[i] && (xb.in_dest[2*i +: 2] == 2'(j));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int j = 0; j < 4; j++) begin
            state_q[j] <= st_idle;
            owner_q[j] <= 2'd0;
            ptr_q[j]   <= 2'd0;
         end
      end else begin
         for (int j = 0; j < 4; j++) begin
            state_q[j] <= state_d[j];
            owner_q[j] <= owner_d[j];
            ptr_q[j]   <= ptr_d[j];
         end
      end
   end

   // Grant, select and next-state per output; outputs never interact.
   always_comb begin
      logic [1:0] idx;
      logic       xfer;
      logic       last;
      idx  = 2'd0;
      xfer = 1'b0;
      last = 1'b0;
      for (int j = 0; j < 4; j++) begin
         state_d[j] = state_q[j];
         owner_d[j] = owner_q[j];
         ptr_d[j]   = ptr_q[j];
         gnt_v[j]   = 1'b0;
         gnt[j]     = 2'd0;
         sel[j]     = 2'd0;
      end
      for (int j = 0; j < 4; j++) begin
         if (state_q[j] == st_idle) begin
            for (int k = 0; k < 4; k++) begin
               idx = ptr_q[j] + 2'(k);
               if (!gnt_v[j] && req[j][idx]) begin
                  gnt_v[j] = 1'b1;
                  gnt[j]   = idx;
               end
            end
         end else if (req[j][owner_q[j]]) begin
            gnt_v[j] = 1'b1;
            gnt[j]   = owner_q[j];
         end

         if (gnt_v[j])
            sel[j] = gnt[j];
         else if (state_q[j] == st_locked)
            sel[j] = owner_q[j];
         else
            sel[j] = ptr_q[j];

         xfer = gnt_v[j] && xb.out_rdy[j];
         last = !p_lock_en || xb.in_last[gnt[j]];

         if (state_q[j] == st_idle) begin
            if (gnt_v[j]) begin
               // A stalled first flit also locks, so sel cannot move under backpressure.
               if (!xfer || !last) begin
                  state_d[j] = st_locked;
                  owner_d[j] = gnt[j];
               end else begin
                  ptr_d[j] = gnt[j] + 2'd1;
               end
            end
         end else if (xfer && last) begin
            state_d[j] = st_idle;
            ptr_d[j]   = owner_q[j] + 2'd1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         rdy_raw[i] = 1'b0;
         for (int j = 0; j < 4; j++) begin
            if (xb.in_dest[2*i +: 2] == 2'(j) && gnt_v[j] && gnt[j] == 2'(i) && xb.out_rdy[j])
               rdy_raw[i] = 1'b1;
         end
      end
   end

   assign xb.in_rdy  = reset ? 4'h0 : rdy_raw;
   assign xb.out_val = reset ? 4'h0 : gnt_v;
   assign xb.sel0    = reset ? 2'd0 : sel[0];
   assign xb.sel1    = reset ? 2'd0 : sel[1];
   assign xb.sel2    = reset ? 2'd0 : sel[2];
   assign xb.sel3    = reset ? 2'd0 : sel[3];

endmodule
